// File: rtl/nw_pkt_decorator_pkg.sv
// nw_pkt_decorator_pkg
//   Shared types for the packet decorator: output beat kinds, the framing
//   FSM states and the header tag width.
package nw_pkt_decorator_pkg;

    localparam int HDR_TAG_W = 8;

    typedef enum logic [1:0] {
        HDR = 2'd0,
        PAY = 2'd1,
        TRL = 2'd2
    } beat_kind_e;

    typedef enum logic [1:0] {
        IDLE,
        HDR_S,
        PAY_S,
        TRL_S
    } state_e;

endpackage

// File: rtl/nw_skid_buffer.sv
// nw_skid_buffer
//   Two-entry valid/ready skid buffer with fully registered outputs.
//   in_ready comes straight from a flop, so it never depends on in_valid.
//   When the output register is idle its payload is zeroed, so a quiet
//   output bus reads as all zeros.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready/in_data    upstream side
//   out_valid/out_ready/out_data downstream side
module nw_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;

    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            // Output slot frees up: drain the skid entry first, else take
            // the incoming beat directly (skid full implies no in_fire).
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                out_data_d  = in_fire ? in_data : '0;
            end
        end else if (in_fire) begin
            // Output stalled: park the beat accepted this cycle.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/nw_pkt_decorator.sv
// nw_pkt_decorator
//   Wraps each payload packet with a header beat {tag, seq, zeros} and a
//   trailer beat {xor checksum} carrying the payload beat count on m_len.
//   All m_* outputs come from a 2-entry skid buffer (1-cycle latency,
//   full throughput, no bubbles between back-to-back packets).
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   s_valid/s_ready/s_data/s_last     payload input stream
//   cfg_tag                           header tag, sampled when a header is scheduled
//   m_valid/m_ready/m_data/m_last     decorated output stream
//   m_kind                            0=HDR 1=PAY 2=TRL
//   m_len                             payload beat count on TRL, else 0
//   err_oversize                      sticky, packet longer than 2^LEN_W-1 beats
// Optional (NW_PKT_DECORATOR_STATS_EN):
//   stat_pkts                         accepted trailers
//   stat_beats                        accepted output beats
module nw_pkt_decorator
    import nw_pkt_decorator_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int SEQ_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [7:0]        cfg_tag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [1:0]        m_kind,
    output logic [LEN_W-1:0]  m_len,
    output logic              err_oversize
`ifdef NW_PKT_DECORATOR_STATS_EN
    ,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_beats
`endif
);

    localparam int PW = DATA_W + 2 + 1 + LEN_W;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_e                 state_q, state_d;
    logic [HDR_TAG_W-1:0]   tag_q, tag_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [DATA_W-1:0]      csum_q, csum_d;
    logic [LEN_W-1:0]       count_q, count_d;
    logic                   err_q, err_d;

    logic                   push_valid, push_ready;
    logic [DATA_W-1:0]      p_data;
    beat_kind_e             p_kind;
    logic                   p_last;
    logic [LEN_W-1:0]       p_len;
    logic [PW-1:0]          push_bus, pop_bus;
    logic [DATA_W-1:0]      hdr_word;

    // Tag in the top byte, sequence number just below it, zero fill.
    assign hdr_word = ({{(DATA_W-HDR_TAG_W){1'b0}}, tag_q} << (DATA_W-HDR_TAG_W))
                    | ({{(DATA_W-SEQ_W){1'b0}}, seq_q} << (DATA_W-HDR_TAG_W-SEQ_W));

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        seq_d      = seq_q;
        csum_d     = csum_q;
        count_d    = count_q;
        err_d      = err_q;
        push_valid = 1'b0;
        p_data     = '0;
        p_kind     = HDR;
        p_last     = 1'b0;
        p_len      = '0;
        s_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    tag_d   = cfg_tag;
                    state_d = HDR_S;
                end
            end
            HDR_S: begin
                push_valid = 1'b1;
                p_data     = hdr_word;
                p_kind     = HDR;
                if (push_ready) state_d = PAY_S;
            end
            PAY_S: begin
                // push_ready is a flop output, so s_ready never sees s_valid.
                s_ready    = push_ready;
                push_valid = s_valid;
                p_data     = s_data;
                p_kind     = PAY;
                if (s_valid && push_ready) begin
                    csum_d = csum_q ^ s_data;
                    if (count_q == LEN_MAX) err_d = 1'b1;
                    else                    count_d = count_q + LEN_W'(1);
                    if (s_last) state_d = TRL_S;
                end
            end
            TRL_S: begin
                push_valid = 1'b1;
                p_data     = csum_q;
                p_kind     = TRL;
                p_last     = 1'b1;
                p_len      = count_q;
                if (push_ready) begin
                    seq_d   = seq_q + SEQ_W'(1);
                    csum_d  = '0;
                    count_d = '0;
                    // Next packet already waiting: go straight to its header.
                    if (s_valid) begin
                        tag_d   = cfg_tag;
                        state_d = HDR_S;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tag_q   <= '0;
            seq_q   <= '0;
            csum_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign push_bus     = {p_data, p_kind, p_last, p_len};
    assign err_oversize = err_q;

    nw_skid_buffer #(.WIDTH(PW)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid),
        .in_ready  (push_ready),
        .in_data   (push_bus),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (pop_bus)
    );

    assign {m_data, m_kind, m_last, m_len} = pop_bus;

`ifdef NW_PKT_DECORATOR_STATS_EN
    logic [31:0] stat_pkts_q, stat_pkts_d;
    logic [31:0] stat_beats_q, stat_beats_d;

    always_comb begin
        stat_pkts_d  = stat_pkts_q;
        stat_beats_d = stat_beats_q;
        if (m_valid && m_ready) begin
            stat_beats_d = stat_beats_q + 32'd1;
            if (m_last) stat_pkts_d = stat_pkts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts_q  <= '0;
            stat_beats_q <= '0;
        end else begin
            stat_pkts_q  <= stat_pkts_d;
            stat_beats_q <= stat_beats_d;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_beats = stat_beats_q;
`endif

endmodule

// File: tb/tb_nw_pkt_decorator.sv
// tb_nw_pkt_decorator
//   Randomized bench for nw_pkt_decorator with a packet-level reference
//   model: every packet handed to the driver is expanded into its expected
//   header / payload / trailer beats, which a monitor pops and compares.
module tb_nw_pkt_decorator;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  kind;
        logic        last;
        logic [7:0]  len;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [7:0]  cfg_tag = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
    logic [1:0]  m_kind;
    logic [7:0]  m_len;
    logic        err_oversize;
`ifdef NW_PKT_DECORATOR_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_beats;
`endif

    nw_pkt_decorator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .cfg_tag      (cfg_tag),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_kind       (m_kind),
        .m_len        (m_len),
        .err_oversize (err_oversize)
`ifdef NW_PKT_DECORATOR_STATS_EN
        ,
        .stat_pkts    (stat_pkts),
        .stat_beats   (stat_beats)
`endif
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    model_seq = 0;
    int    rdy_mode = 0;     // 0: always ready, 1: random 50%, 2: never
    bit    bubble_en = 1'b0;
    int    bubbles = 0;
    int    max_run = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a packet of n payload words becomes HDR, payload, TRL.
    task automatic model_pkt(input logic [7:0] tag, input logic [31:0] pay[$]);
        beat_t       b;
        logic [31:0] csum = '0;
        int          n = pay.size();
        b = '{data: {tag, 8'(model_seq), 16'h0}, kind: 2'd0, last: 1'b0, len: 8'd0};
        exp_q.push_back(b);
        foreach (pay[i]) begin
            b = '{data: pay[i], kind: 2'd1, last: 1'b0, len: 8'd0};
            exp_q.push_back(b);
            csum ^= pay[i];
        end
        b = '{data: csum, kind: 2'd2, last: 1'b1, len: 8'((n > 255) ? 255 : n)};
        exp_q.push_back(b);
        model_seq = (model_seq + 1) % 256;
    endtask

    // Ready generator, applied just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom % 2);
            default: m_ready = 1'b0;
        endcase
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit    prev_stall = 1'b0;
        bit    in_run = 1'b0;
        int    run_len = 0;
        beat_t prev_b, cur, e;
        forever begin
            @(negedge clk);
            cur = '{data: m_data, kind: m_kind, last: m_last, len: m_len};
            if (!rst_n) begin
                prev_stall = 1'b0;
                in_run = 1'b0;
                run_len = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(m_valid), 64'd1);
                    chk("stall_beat", 64'(cur), 64'(prev_b));
                end
                if (m_valid) begin
                    in_run = 1'b1;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                    if (bubble_en && in_run && exp_q.size() != 0) bubbles++;
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("m_data", 64'(m_data), 64'(e.data));
                        chk("m_kind", 64'(m_kind), 64'(e.kind));
                        chk("m_last", 64'(m_last), 64'(e.last));
                        chk("m_len", 64'(m_len), 64'(e.len));
                    end
                end
                if (exp_q.size() == 0) in_run = 1'b0;
                prev_stall = m_valid && !m_ready;
                prev_b = cur;
            end
        end
    end

    // Drives one beat; returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [31:0] d, input logic l);
        logic rdy;
        int   t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 1000) begin
                chk("s_accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic send_pkt(input logic [7:0] tag, input logic [31:0] pay[$], input bit keep_valid);
        model_pkt(tag, pay);
        cfg_tag = tag;
        foreach (pay[i]) begin
            send_beat(pay[i], i == pay.size() - 1);
            // Tag wiggles mid-packet must not reach this packet's header.
            if (i == 0) cfg_tag = 8'($urandom);
        end
        if (!keep_valid) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        rst_n   = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_kind", 64'(m_kind), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_len", 64'(m_len), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_err", 64'(err_oversize), 64'd0);
`ifdef NW_PKT_DECORATOR_STATS_EN
        chk("rst_stat_pkts", 64'(stat_pkts), 64'd0);
        chk("rst_stat_beats", 64'(stat_beats), 64'd0);
`endif
        exp_q.delete();
        model_seq = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bubbles = 0;
        max_run = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pay[$];
        @(posedge clk);
        #1;
        do_reset();

        // 3-beat packet, always ready: 5 consecutive beats.
        rdy_mode = 0;
        bubble_en = 1'b1;
        @(posedge clk);
        #1;
        pay = '{32'h11, 32'h22, 32'h44};
        send_pkt(8'hA5, pay, 1'b0);
        drain();
        chk("pkt3_bubbles", 64'(bubbles), 64'd0);
        chk("pkt3_run", 64'(max_run), 64'd5);
`ifdef NW_PKT_DECORATOR_STATS_EN
        chk("stat_pkts", 64'(stat_pkts), 64'd1);
        chk("stat_beats", 64'(stat_beats), 64'd5);
`endif

        // Two back-to-back 1-beat packets: 6 consecutive beats.
        do_reset();
        pay = '{32'hDEADBEEF};
        send_pkt(8'h3C, pay, 1'b1);
        send_pkt(8'h3C, pay, 1'b0);
        drain();
        chk("b2b_bubbles", 64'(bubbles), 64'd0);
        chk("b2b_run", 64'(max_run), 64'd6);
        bubble_en = 1'b0;

        // 10-beat packet under random backpressure.
        rdy_mode = 1;
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back($urandom);
        send_pkt(8'($urandom), pay, 1'b0);
        drain();

        // Downstream blocked: buffer fills, input must stall, nothing lost.
        rdy_mode = 2;
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back($urandom);
        fork
            send_pkt(8'h5A, pay, 1'b0);
            begin
                repeat (30) @(posedge clk);
                #1;
                chk("full_s_ready", 64'(s_ready), 64'd0);
                chk("full_m_valid", 64'(m_valid), 64'd1);
                chk("full_m_kind", 64'(m_kind), 64'd0);
                rdy_mode = 0;
            end
        join
        drain();

        // Sequence wrap: 257 headers after reset, the last carries seq 0.
        do_reset();
        for (int p = 0; p < 257; p++) begin
            pay = '{32'($urandom)};
            send_pkt(8'($urandom), pay, p != 256);
        end
        drain();

        // Random packets, gaps and backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 20; p++) begin
            pay.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) pay.push_back($urandom);
            send_pkt(8'($urandom), pay, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        // Oversize: 300 beats, count saturates at 255, error from beat 256.
        rdy_mode = 0;
        pay.delete();
        for (int i = 0; i < 300; i++) pay.push_back($urandom);
        model_pkt(8'hC3, pay);
        cfg_tag = 8'hC3;
        for (int i = 0; i < 300; i++) begin
            send_beat(pay[i], i == 299);
            if (i == 254) chk("err_at_255", 64'(err_oversize), 64'd0);
            if (i == 255) chk("err_at_256", 64'(err_oversize), 64'd1);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        drain();
        chk("err_sticky", 64'(err_oversize), 64'd1);

        // Reset after beat 2 of a 5-beat packet; next packet starts clean.
        do_reset();
        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back($urandom);
        model_pkt(8'h77, pay);
        cfg_tag = 8'h77;
        send_beat(pay[0], 1'b0);
        send_beat(pay[1], 1'b0);
        do_reset();
        pay = '{32'h0F0F0F0F, 32'h00FF00FF, 32'h12345678};
        send_pkt(8'h99, pay, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
